regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
Write-side driver for the RV32I 32x32 register file. It accepts retiring results from the execute stage and waits on the data-memory response for loads. It performs load byte/half extraction and sign/zero extension, then drives the register file write port (oprd, wrt_en, wrt_data) with a single-cycle write strobe. x0 writes are suppressed here, so the register file never sees a write to register 0.

Parameters:
DATA_W, 32, datapath width; only 32 is supported.
LOAD_TIMEOUT, 255, cycles to wait for mem_rvalid before abandoning a load; 8-bit counter range 1..255.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  execute stage presents a retiring instruction
in_ready  output  1  block accepts in_* this cycle
in_rd  input  5  destination register index
in_sel  input  2  result source: 00 ALU, 01 load, 10 PC+4, 11 immediate (LUI)
in_alu  input  32  ALU result
in_pc4  input  32  PC+4 (JAL/JALR link)
in_imm  input  32  upper immediate
in_funct3  input  3  load size/sign (RV32I encoding)
in_addr_lo  input  2  load address bits [1:0]
mem_rvalid  input  1  data memory read response valid
mem_rdata  input  32  data memory read word, aligned
oprd  output  5  register file write index
wrt_en  output  1  register file write strobe
wrt_data  output  32  register file write data
busy  output  1  high in WAIT_LOAD
load_err  output  1  one-cycle pulse on load timeout

Behaviour:
- Reset (rst=0, async): state=IDLE; oprd=0, wrt_en=0, wrt_data=0, load_err=0, timeout counter=0. Any load in flight is discarded. A mem_rvalid arriving after reset is ignored.
- in_ready = (state==IDLE) | (state==WRITE). A transfer occurs when in_valid & in_ready.
- States:
  - IDLE.
  - WAIT_LOAD: load accepted, awaiting mem_rvalid.
  - WRITE: wrt_en asserted this cycle.
- Transitions:
  - Accept with in_sel != 01 -> WRITE next cycle. wrt_data is the selected source, oprd=in_rd. Latency is 1 cycle from accept.
  - Accept with in_sel == 01 -> WAIT_LOAD. Latch rd, funct3, addr_lo; clear the counter.
  - WAIT_LOAD & mem_rvalid -> WRITE next cycle with extracted data.
  - WAIT_LOAD & no rvalid: counter increments. When counter reaches LOAD_TIMEOUT-1 without rvalid, go to IDLE with load_err=1 for one cycle and no write.
  - WRITE with a new accept: chain directly into WRITE or WAIT_LOAD, giving back-to-back writes at 1 per cycle for non-loads.
  - WRITE with no accept -> IDLE.
- wrt_en is high only in WRITE and only when the latched rd != 0. For rd==0 the block still passes through WRITE, with wrt_en=0 and wrt_data still updated.
- oprd and wrt_data are registered and hold their last value when wrt_en=0.
- Load extraction from mem_rdata, byte select = addr_lo:
  - 000 LB: sign-extend the byte.
  - 100 LBU: zero-extend the byte.
  - 001 LH: sign-extend the half selected by addr_lo[1] (addr_lo[0] ignored).
  - 101 LHU: zero-extend that half.
  - 010 LW and reserved codes 011/110/111: full word.
- mem_rvalid outside WAIT_LOAD is ignored.
- in_valid while in WAIT_LOAD is not accepted (in_ready=0). Upstream holds its inputs.

Optional Feature:
Macro WB_COUNT_EN.
- Defined: adds output wb_count[31:0], reset to 0, incremented on every cycle wrt_en=1; wraps 0xFFFFFFFF->0.
- Undefined: port and counter absent; no other behaviour changes.

Test Plan:
- ALU write: accept rd=5, sel=00, alu=0x12345678 -> next cycle wrt_en=1, oprd=5, wrt_data=0x12345678; following cycle wrt_en=0.
- x0 suppression: accept rd=0, sel=10, pc4=0x100 -> wrt_en stays 0 for the whole sequence.
- LB sign: accept rd=3, sel=01, funct3=000, addr_lo=2; rvalid after 4 cycles with rdata=0x00800000 -> busy for 4 cycles, then wrt_data=0xFFFFFF80, oprd=3. Repeat with LBU -> 0x00000080.
- LH/LW: rdata=0x8001ABCD, LH addr_lo=2 -> 0xFFFF8001; LHU addr_lo=0 -> 0x0000ABCD; LW -> 0x8001ABCD.
- Back-to-back: in_valid held for 3 ALU results rd=1,2,3 -> wrt_en high for 3 consecutive cycles with matching oprd/data.
- Timeout/reset: load accepted, no rvalid -> load_err pulse after 255 cycles, no write, in_ready=1.
- Reset mid-load: rst low during WAIT_LOAD, then a late rvalid -> no write; all outputs 0.

Source files
------------

// File: rtl/regfile_writeback.sv
// RV32I register-file write driver: result select, load extract/extend, x0 suppression (WB_COUNT_EN adds wb_count).
// Latency: 1 cycle from accept for non-loads, 1 cycle after mem_rvalid for loads.
// Backpressure: in_ready low while a load waits on memory; timeout after LOAD_TIMEOUT cycles.
module regfile_writeback #(
    parameter int DATA_W       = 32,
    parameter int LOAD_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rd,
    input  logic [1:0]        in_sel,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [4:0]        oprd,
    output logic              wrt_en,
    output logic [DATA_W-1:0] wrt_data,
    output logic              busy,
    output logic              load_err
`ifdef WB_COUNT_EN
    ,
    output logic [31:0]       wb_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_LOAD = 2'd1,
        S_WRITE     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [4:0]        rd_q, rd_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        alo_q, alo_d;
    logic [4:0]        oprd_q, oprd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wen_q, wen_d;
    logic              err_q, err_d;

    logic              accept;
    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [DATA_W-1:0] ld_data;
    logic [DATA_W-1:0] nl_data;

    assign in_ready = (state_q == S_IDLE) || (state_q == S_WRITE);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q == S_WAIT_LOAD);
    assign oprd     = oprd_q;
    assign wrt_en   = wen_q;
    assign wrt_data = wdata_q;
    assign load_err = err_q;

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (alo_q)
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            2'd3:    ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        // Halfword select ignores addr bit 0; misaligned halves are not split.
        ld_half = alo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{(DATA_W-8){ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {{(DATA_W-8){1'b0}}, ld_byte};
            3'b001:  ld_data = {{(DATA_W-16){ld_half[15]}}, ld_half};
            3'b101:  ld_data = {{(DATA_W-16){1'b0}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        case (in_sel)
            2'b10:   nl_data = in_pc4;
            2'b11:   nl_data = in_imm;
            default: nl_data = in_alu;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        alo_d   = alo_q;
        oprd_d  = oprd_q;
        wdata_d = wdata_q;
        wen_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE, S_WRITE: begin
                if (accept) begin
                    if (in_sel == 2'b01) begin
                        state_d = S_WAIT_LOAD;
                        rd_d    = in_rd;
                        f3_d    = in_funct3;
                        alo_d   = in_addr_lo;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = S_WRITE;
                        oprd_d  = in_rd;
                        wdata_d = nl_data;
                        wen_d   = (in_rd != 5'd0);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_LOAD: begin
                if (mem_rvalid) begin
                    state_d = S_WRITE;
                    oprd_d  = rd_q;
                    wdata_d = ld_data;
                    wen_d   = (rd_q != 5'd0);
                end else if (cnt_q == 8'(LOAD_TIMEOUT - 1)) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            rd_q    <= 5'd0;
            f3_q    <= 3'd0;
            alo_q   <= 2'd0;
            oprd_q  <= 5'd0;
            wdata_q <= '0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
            oprd_q  <= oprd_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
        end
    end

`ifdef WB_COUNT_EN
    logic [31:0] wb_count_q, wb_count_d;

    assign wb_count   = wb_count_q;
    assign wb_count_d = wen_q ? wb_count_q + 32'd1 : wb_count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_count_q <= 32'd0;
        end else begin
            wb_count_q <= wb_count_d;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a transaction-level expectation model.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_sel;
    logic [31:0] in_alu;
    logic [31:0] in_pc4;
    logic [31:0] in_imm;
    logic [2:0]  in_funct3;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  oprd;
    logic        wrt_en;
    logic [31:0] wrt_data;
    logic        busy;
    logic        load_err;
`ifdef WB_COUNT_EN
    logic [31:0] wb_count;
`endif

    regfile_writeback #(.DATA_W(32), .LOAD_TIMEOUT(255)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_sel     (in_sel),
        .in_alu     (in_alu),
        .in_pc4     (in_pc4),
        .in_imm     (in_imm),
        .in_funct3  (in_funct3),
        .in_addr_lo (in_addr_lo),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .oprd       (oprd),
        .wrt_en     (wrt_en),
        .wrt_data   (wrt_data),
        .busy       (busy),
        .load_err   (load_err)
`ifdef WB_COUNT_EN
        ,
        .wb_count   (wb_count)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic        check_en = 1'b0;
    logic        e_wen, e_busy, e_err;
    logic [4:0]  m_oprd;
    logic [31:0] m_data;
    int          n_wr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected result of a load, written directly from the RV32I load rules.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] alo,
                                            input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * alo)) & 32'hFF;
        h = (w >> (16 * alo[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 128) ? b - 256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32768) ? h - 65536 : h;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            check("wrt_en",   {31'b0, wrt_en},   {31'b0, e_wen});
            check("oprd",     {27'b0, oprd},     {27'b0, m_oprd});
            check("wrt_data", wrt_data,          m_data);
            check("busy",     {31'b0, busy},     {31'b0, e_busy});
            check("load_err", {31'b0, load_err}, {31'b0, e_err});
            check("in_ready", {31'b0, in_ready}, {31'b0, !e_busy});
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        e_wen  = 1'b0;
        e_busy = 1'b0;
        e_err  = 1'b0;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] d);
        m_oprd = rd;
        m_data = d;
        e_wen  = (rd != 5'd0);
        e_busy = 1'b0;
        e_err  = 1'b0;
        if (rd != 5'd0) n_wr++;
    endtask

    // Non-load retire; unselected sources carry distinct decoy values.
    task automatic op_nl(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] v);
        in_valid = 1'b1;
        in_rd    = rd;
        in_sel   = sel;
        in_alu   = (sel == 2'b00) ? v : ~v;
        in_pc4   = (sel == 2'b10) ? v : v ^ 32'h5A5A_5A5A;
        in_imm   = (sel == 2'b11) ? v : v + 32'd1;
        tick();
        in_valid = 1'b0;
        wr(rd, v);
    endtask

    // Load retire; rvalid arrives in the last of wait_cyc busy cycles.
    task automatic op_ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo,
                         input logic [31:0] w, input int wait_cyc);
        in_valid   = 1'b1;
        in_rd      = rd;
        in_sel     = 2'b01;
        in_funct3  = f3;
        in_addr_lo = alo;
        in_alu     = 32'hDEAD_BEEF;
        tick();
        in_valid   = 1'b0;
        in_funct3  = ~f3;
        in_addr_lo = ~alo;
        e_wen = 1'b0; e_busy = 1'b1; e_err = 1'b0;
        for (int i = 1; i <= wait_cyc; i++) begin
            mem_rvalid = (i == wait_cyc);
            mem_rdata  = (i == wait_cyc) ? w : ~w;
            tick();
        end
        mem_rvalid = 1'b0;
        wr(rd, extract(f3, alo, w));
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_rd = 5'd0; in_sel = 2'd0;
        in_alu = 32'd0; in_pc4 = 32'd0; in_imm = 32'd0; in_funct3 = 3'd0;
        in_addr_lo = 2'd0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
        m_oprd = 5'd0; m_data = 32'd0;
        idle();
        tick();
        tick();
        check("rst_oprd",  {27'b0, oprd},     32'd0);
        check("rst_wen",   {31'b0, wrt_en},   32'd0);
        check("rst_data",  wrt_data,          32'd0);
        check("rst_busy",  {31'b0, busy},     32'd0);
        check("rst_err",   {31'b0, load_err}, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check_en = 1'b1;
        rst = 1'b1;
        tick();

        op_nl(5'd5, 2'b00, 32'h1234_5678);
        check("alu_wen",  {31'b0, wrt_en}, 32'd1);
        check("alu_oprd", {27'b0, oprd},   32'd5);
        check("alu_data", wrt_data,        32'h1234_5678);
        tick(); idle();
        check("alu_wen_drop", {31'b0, wrt_en}, 32'd0);

        op_nl(5'd0, 2'b10, 32'h0000_0100);
        check("x0_wen",  {31'b0, wrt_en}, 32'd0);
        check("x0_data", wrt_data,        32'h0000_0100);
        tick(); idle();

        op_ld(5'd3, 3'b000, 2'd2, 32'h0080_0000, 4);
        check("lb_data", wrt_data,      32'hFFFF_FF80);
        check("lb_oprd", {27'b0, oprd}, 32'd3);
        tick(); idle();
        op_ld(5'd3, 3'b100, 2'd2, 32'h0080_0000, 4);
        check("lbu_data", wrt_data, 32'h0000_0080);
        tick(); idle();

        op_ld(5'd7, 3'b001, 2'd2, 32'h8001_ABCD, 1);
        check("lh_data", wrt_data, 32'hFFFF_8001);
        op_ld(5'd8, 3'b101, 2'd0, 32'h8001_ABCD, 2);
        check("lhu_data", wrt_data, 32'h0000_ABCD);
        op_ld(5'd9, 3'b010, 2'd3, 32'h8001_ABCD, 3);
        check("lw_data", wrt_data, 32'h8001_ABCD);
        op_ld(5'd10, 3'b011, 2'd1, 32'h8001_ABCD, 1);
        check("rsv_data", wrt_data, 32'h8001_ABCD);
        op_ld(5'd11, 3'b000, 2'd3, 32'h8001_ABCD, 2);
        check("lb3_data", wrt_data, 32'hFFFF_FF80);
        op_ld(5'd12, 3'b101, 2'd3, 32'h8001_ABCD, 1);
        check("lhu3_data", wrt_data, 32'h0000_8001);
        op_ld(5'd0, 3'b010, 2'd0, 32'hCAFE_F00D, 2);
        check("ld_x0_wen", {31'b0, wrt_en}, 32'd0);
        tick(); idle();

        mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
        tick(); tick();
        mem_rvalid = 1'b0;
        tick();

        op_nl(5'd1, 2'b00, 32'h0000_0011);
        op_nl(5'd2, 2'b11, 32'hABCD_E000);
        op_nl(5'd3, 2'b10, 32'h0000_2004);
        check("b2b_oprd", {27'b0, oprd}, 32'd3);
        check("b2b_data", wrt_data,      32'h0000_2004);
        tick(); idle();

        in_valid = 1'b1; in_rd = 5'd13; in_sel = 2'b01; in_funct3 = 3'b010; in_addr_lo = 2'd0;
        tick();
        in_valid = 1'b0;
        e_wen = 1'b0; e_busy = 1'b1; e_err = 1'b0;
        repeat (254) tick();
        tick();
        e_busy = 1'b0; e_err = 1'b1;
        check("to_err",   {31'b0, load_err}, 32'd1);
        check("to_ready", {31'b0, in_ready}, 32'd1);
        check("to_wen",   {31'b0, wrt_en},   32'd0);
        tick(); idle();
        check("to_err_drop", {31'b0, load_err}, 32'd0);
`ifdef WB_COUNT_EN
        check("wb_count", wb_count, 32'(n_wr));
`endif

        in_valid = 1'b1; in_rd = 5'd4; in_sel = 2'b01; in_funct3 = 3'b000; in_addr_lo = 2'd1;
        tick();
        in_valid = 1'b0;
        e_busy = 1'b1;
        tick(); tick();
        rst = 1'b0;
        m_oprd = 5'd0; m_data = 32'd0; idle();
        #1;
        check("mid_rst_oprd", {27'b0, oprd}, 32'd0);
        check("mid_rst_data", wrt_data,      32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        tick();
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_FF00;
        tick();
        rst = 1'b1;
        tick(); tick();
        mem_rvalid = 1'b0;
        tick();
        check("late_rv_wen",  {31'b0, wrt_en}, 32'd0);
        check("late_rv_data", wrt_data,        32'd0);
`ifdef WB_COUNT_EN
        check("wb_count_rst", wb_count, 32'd0);
`endif
        check_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
